// File: rtl/key_lookup_pkg.sv
// Shared definitions for the reverse (data->key) lookup scanner:
// FSM state encodings and the index-width helper used for wr_idx / scan index.
package key_lookup_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Index width: a single-entry table still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_lookup_table.sv
// NR_KEY-entry {key,data} register file with per-entry valid bits.
// Ports:
//   clk, rst_n               clock, async active-low reset (clears all entries)
//   wr_en/wr_idx/wr_key/wr_data  write port; out-of-range indices are dropped
//   rd_idx                   read index
//   rd_key_c/rd_data_c/rd_valid_c  asynchronous read of entry rd_idx
module key_lookup_table
  import key_lookup_pkg::*;
#(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 4,
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [KEY_LEN-1:0]  rd_key_c,
  output logic [DATA_LEN-1:0] rd_data_c,
  output logic                rd_valid_c
);

  logic [KEY_LEN-1:0]  key_q   [NR_KEY];
  logic [DATA_LEN-1:0] data_q  [NR_KEY];
  logic                valid_q [NR_KEY];
  logic                wr_in_range;

  // Range check only exists when the index field can encode past the table end.
  if ((2 ** IDX_W) > NR_KEY) begin : g_range_chk
    assign wr_in_range = (32'(wr_idx) < NR_KEY);
  end else begin : g_range_full
    assign wr_in_range = 1'b1;
  end

  // Entry storage; writes allowed in any scanner state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NR_KEY); i++) begin
        key_q[i]   <= '0;
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en && wr_in_range) begin
      key_q[wr_idx]   <= wr_key;
      data_q[wr_idx]  <= wr_data;
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Registered contents only: a same-cycle write is not visible to the reader.
  assign rd_key_c   = key_q[rd_idx];
  assign rd_data_c  = data_q[rd_idx];
  assign rd_valid_c = valid_q[rd_idx];

endmodule

// File: rtl/key_lookup_scanner.sv
// Reverse lookup: scans the {key,data} table one entry per cycle and returns the
// key of the lowest-index valid entry whose data equals the requested value.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wr_en/wr_idx/wr_key/wr_data      table write port
//   req_valid/req_ready/req_data     search request handshake
//   rsp_valid/rsp_ready/rsp_key/rsp_hit  response handshake and result
//   default_key                      key returned on a miss when HAS_DEFAULT=1
//   busy                             scanner not idle
module key_lookup_scanner
  import key_lookup_pkg::*;
#(
  parameter  int unsigned NR_KEY      = 4,
  parameter  int unsigned KEY_LEN     = 4,
  parameter  int unsigned DATA_LEN    = 8,
  parameter  int unsigned HAS_DEFAULT = 1,
  localparam int unsigned IDX_W       = idx_width(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [KEY_LEN-1:0]  rsp_key,
  output logic                rsp_hit,
  input  logic [KEY_LEN-1:0]  default_key,
  output logic                busy
);

  logic [1:0]          state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [DATA_LEN-1:0] req_data_q,  req_data_d;
  logic [KEY_LEN-1:0]  rsp_key_q,   rsp_key_d;
  logic                rsp_hit_q,   rsp_hit_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q,      busy_d;

  logic [KEY_LEN-1:0]  rd_key_c;
  logic [DATA_LEN-1:0] rd_data_c;
  logic                rd_valid_c;
  logic                match_c;
  logic                last_c;
  logic [KEY_LEN-1:0]  miss_key_c;

  key_lookup_table #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_key     (wr_key),
    .wr_data    (wr_data),
    .rd_idx     (idx_q),
    .rd_key_c   (rd_key_c),
    .rd_data_c  (rd_data_c),
    .rd_valid_c (rd_valid_c)
  );

  assign match_c    = rd_valid_c && (rd_data_c == req_data_q);
  assign last_c     = (32'(idx_q) == (NR_KEY - 1));
  assign miss_key_c = (HAS_DEFAULT != 0) ? default_key : '0;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      req_data_q  <= '0;
      rsp_key_q   <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_data_q  <= req_data_d;
      rsp_key_q   <= rsp_key_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req_data_d = req_data_q;
    rsp_key_d  = rsp_key_q;
    rsp_hit_d  = rsp_hit_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_data_d = req_data;
          idx_d      = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (match_c) begin
          rsp_key_d = rd_key_c;
          rsp_hit_d = 1'b1;
          state_d   = ST_RESP;
        end else if (last_c) begin
          rsp_key_d = miss_key_c;
          rsp_hit_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // rsp_valid rises on the second RESP cycle (result regs settle first) and
    // drops on the handshake edge; ready only returns once IDLE is registered.
    rsp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_key   = rsp_key_q;
  assign rsp_hit   = rsp_hit_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_lookup_scanner.sv
// Directed bench for key_lookup_scanner: a 4-entry instance with default key
// and a 3-entry instance without, sharing clock, reset and write port.
module tb_key_lookup_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic [7:0] wr_data;
  logic       req_valid, req_valid2;
  logic [7:0] req_data;
  logic       rsp_ready;
  logic [3:0] default_key;

  logic       req_ready, rsp_valid, rsp_hit, busy;
  logic [3:0] rsp_key;
  logic       req_ready2, rsp_valid2, rsp_hit2, busy2;
  logic [3:0] rsp_key2;

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;

  always #5 clk = ~clk;

  key_lookup_scanner dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key), .rsp_hit(rsp_hit), .default_key(default_key), .busy(busy)
  );

  key_lookup_scanner #(.NR_KEY(3), .HAS_DEFAULT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_data(req_data), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key2), .rsp_hit(rsp_hit2), .default_key(default_key), .busy(busy2)
  );

  logic       s_valid, s_ready, s_hit, s_busy;
  logic [3:0] s_key;
  assign s_valid = sel ? rsp_valid2 : rsp_valid;
  assign s_ready = sel ? req_ready2 : req_ready;
  assign s_hit   = sel ? rsp_hit2   : rsp_hit;
  assign s_busy  = sel ? busy2      : busy;
  assign s_key   = sel ? rsp_key2   : rsp_key;

  typedef struct {
    logic [7:0] data;
    logic [3:0] dkey;
    logic       hit;
    logic [3:0] key;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] key, input logic [7:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Drives the request through its accept edge (edge 0).
  task automatic start_req(input logic [7:0] data, input logic [3:0] dkey);
    chk("req_ready before request", int'(s_ready), 1);
    req_data    = data;
    default_key = dkey;
    if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
  endtask

  // Counts edges from accept until rsp_valid, checks result, optional back-pressure, handshake.
  task automatic wait_rsp(input string name, input logic exp_hit, input logic [3:0] exp_key,
                          input int exp_lat, input int already, input int hold);
    int n;
    bit seen;
    n = already;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = s_valid;
    end
    chk({name, " latency"}, seen ? n : -1, exp_lat);
    if (seen) begin
      chk({name, " hit"}, int'(s_hit), int'(exp_hit));
      chk({name, " key"}, int'(s_key), int'(exp_key));
      chk({name, " busy in resp"}, int'(s_busy), 1);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        chk({name, " held valid"}, int'(s_valid), 1);
        chk({name, " held key"}, int'(s_key), int'(exp_key));
        chk({name, " held hit"}, int'(s_hit), int'(exp_hit));
        chk({name, " req_ready while held"}, int'(s_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, " valid after handshake"}, int'(s_valid), 0);
      chk({name, " req_ready after handshake"}, int'(s_ready), 1);
      chk({name, " busy after handshake"}, int'(s_busy), 0);
    end
  endtask

  task automatic do_req(input string name, input logic [7:0] data, input logic [3:0] dkey,
                        input logic exp_hit, input logic [3:0] exp_key, input int exp_lat,
                        input int hold);
    rsp_ready = (hold == 0);
    start_req(data, dkey);
    wait_rsp(name, exp_hit, exp_key, exp_lat, 0, hold);
  endtask

  initial begin
    vecs[0] = '{data: 8'hAB, dkey: 4'hF, hit: 1'b1, key: 4'h7, lat: 4};
    vecs[1] = '{data: 8'h11, dkey: 4'hF, hit: 1'b1, key: 4'h3, lat: 2};
    vecs[2] = '{data: 8'h55, dkey: 4'hF, hit: 1'b1, key: 4'h2, lat: 3};
    vecs[3] = '{data: 8'h99, dkey: 4'hC, hit: 1'b0, key: 4'hC, lat: 5};
    vecs[4] = '{data: 8'h00, dkey: 4'h5, hit: 1'b0, key: 4'h5, lat: 5};

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
    req_valid = 1'b0; req_valid2 = 1'b0; req_data = '0; rsp_ready = 1'b1;
    default_key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", int'(req_ready), 1);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_key", int'(rsp_key), 0);
    chk("reset rsp_hit", int'(rsp_hit), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;

    // Empty table: full scan miss with default key.
    do_req("empty", 8'h11, 4'hF, 1'b0, 4'hF, 5, 0);

    wr(2'd0, 4'h3, 8'h11);
    wr(2'd2, 4'h7, 8'hAB);
    wr(2'd1, 4'h2, 8'h55);
    wr(2'd3, 4'h9, 8'h55);

    for (int i = 0; i < 5; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].dkey, vecs[i].hit,
             vecs[i].key, vecs[i].lat, 0);
    end

    // Back-pressure: response held stable for 6 cycles.
    do_req("hold", 8'hAB, 4'hF, 1'b1, 4'h7, 4, 6);

    // Overwrite entry 0 on the very edge it is compared: old contents win.
    rsp_ready = 1'b1;
    start_req(8'h11, 4'hF);
    wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h4; wr_data = 8'h22;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("overwrite no early valid", int'(rsp_valid), 0);
    wait_rsp("overwrite old", 1'b1, 4'h3, 2, 1, 0);
    do_req("overwrite new", 8'h22, 4'hF, 1'b1, 4'h4, 2, 0);
    do_req("overwrite gone", 8'h11, 4'hE, 1'b0, 4'hE, 5, 0);

    // Reset in the middle of a scan.
    start_req(8'h55, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midscan rst rsp_valid", int'(rsp_valid), 0);
    chk("midscan rst busy", int'(busy), 0);
    chk("midscan rst req_ready", int'(req_ready), 1);
    chk("midscan rst rsp_hit", int'(rsp_hit), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req("post rst 55", 8'h55, 4'hF, 1'b0, 4'hF, 5, 0);
    do_req("post rst 22", 8'h22, 4'h6, 1'b0, 4'h6, 5, 0);

    // Out-of-range index on the 3-entry instance; no default key there.
    wr(2'd3, 4'hA, 8'h66);
    wr(2'd1, 4'h6, 8'h77);
    do_req("big idx3 hit", 8'h66, 4'hF, 1'b1, 4'hA, 5, 0);
    sel = 1'b1;
    do_req("small idx3 dropped", 8'h66, 4'hF, 1'b0, 4'h0, 4, 0);
    do_req("small idx1 hit", 8'h77, 4'hF, 1'b1, 4'h6, 3, 0);
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
